// File: rtl/dac_ramp_sched.sv
// dac_ramp_sched: triangular sweep generator for one half of the two-channel
// DAC word, merged with manual single-code writes to either half.
module dac_ramp_sched #(
    parameter int DW      = 14,
    parameter int DWELL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic [15:0]       cfg_data_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              chan_sel_i,
    input  logic              man_wr_i,
    input  logic              man_sel_i,
    input  logic [DW-1:0]     man_code_i,
    output logic [2*DW-1:0]   dac_dat_o,
    output logic              dac_wrt_o,
    output logic              busy_o,
    output logic [DW-1:0]     code_o,
    output logic              dir_o,
    output logic              err_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [DW-1:0]       cfg_min, cfg_max, cfg_step;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic [DW-1:0]       s_min, s_max, s_step;
    logic [DWELL_W-1:0]  s_dwell;
    logic                s_chan;
    logic [DWELL_W-1:0]  cnt, cnt_nxt;
    logic [2*DW-1:0]     dat_nxt;
    logic                wrt_nxt, dir_nxt, err_nxt, accept;
    logic [DW-1:0]       code_nxt;
    logic [DW:0]         up_sum, dn_dif;
    logic                cfg_unused;

    // Upper config data bits are not used by the code/step registers.
    assign cfg_unused = &{1'b0, cfg_data_i[15:DW]};

    assign up_sum = {1'b0, code_o} + {1'b0, s_step};
    assign dn_dif = {1'b0, code_o} - {1'b0, s_step};

    // Config registers, writable at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_min   <= '0;
            cfg_max   <= '1;
            cfg_step  <= DW'(1);
            cfg_dwell <= '0;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                2'd0:    cfg_min   <= cfg_data_i[DW-1:0];
                2'd1:    cfg_max   <= cfg_data_i[DW-1:0];
                2'd2:    cfg_step  <= cfg_data_i[DW-1:0];
                default: cfg_dwell <= cfg_data_i[DWELL_W-1:0];
            endcase
        end
    end

    // State, shadow config and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            s_min     <= '0;
            s_max     <= '0;
            s_step    <= '0;
            s_dwell   <= '0;
            s_chan    <= 1'b0;
            dac_dat_o <= '0;
            dac_wrt_o <= 1'b0;
            code_o    <= '0;
            dir_o     <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dac_dat_o <= dat_nxt;
            dac_wrt_o <= wrt_nxt;
            code_o    <= code_nxt;
            dir_o     <= dir_nxt;
            err_o     <= err_nxt;
            busy_o    <= (state_nxt == RUN);
            if (accept) begin
                s_min   <= cfg_min;
                s_max   <= cfg_max;
                s_step  <= cfg_step;
                s_dwell <= cfg_dwell;
                s_chan  <= chan_sel_i;
            end
        end
    end

    // Next-state, ramp advance and DAC word merge.
    // Manual data is merged first; a start or advance then owns the ramped half.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dat_nxt   = dac_dat_o;
        wrt_nxt   = 1'b0;
        code_nxt  = code_o;
        dir_nxt   = dir_o;
        err_nxt   = err_o;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (man_wr_i) begin
                    if (man_sel_i) dat_nxt[2*DW-1:DW] = man_code_i;
                    else           dat_nxt[DW-1:0]    = man_code_i;
                    wrt_nxt = 1'b1;
                end
                if (start_i && !stop_i) begin
                    if ((cfg_min < cfg_max) && (cfg_step != '0)) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        code_nxt  = cfg_min;
                        dir_nxt   = 1'b0;
                        err_nxt   = 1'b0;
                        if (chan_sel_i) dat_nxt[2*DW-1:DW] = cfg_min;
                        else            dat_nxt[DW-1:0]    = cfg_min;
                        wrt_nxt   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (man_wr_i && (man_sel_i != s_chan)) begin
                    if (man_sel_i) dat_nxt[2*DW-1:DW] = man_code_i;
                    else           dat_nxt[DW-1:0]    = man_code_i;
                    wrt_nxt = 1'b1;
                end
                if (stop_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == s_dwell) begin
                    cnt_nxt = '0;
                    if (!dir_o) begin
                        if (up_sum >= {1'b0, s_max}) begin
                            code_nxt = s_max;
                            dir_nxt  = 1'b1;
                        end else begin
                            code_nxt = up_sum[DW-1:0];
                        end
                    end else begin
                        if (dn_dif[DW] || (dn_dif[DW-1:0] <= s_min)) begin
                            code_nxt = s_min;
                            dir_nxt  = 1'b0;
                        end else begin
                            code_nxt = dn_dif[DW-1:0];
                        end
                    end
                    if (s_chan) dat_nxt[2*DW-1:DW] = code_nxt;
                    else        dat_nxt[DW-1:0]    = code_nxt;
                    wrt_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_ramp_sched.sv
// Testbench for dac_ramp_sched: time-based sweep reference model with
// randomized manual traffic and directed boundary scenarios.
module tb_dac_ramp_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [15:0] cfg_data_i;
    logic        start_i, stop_i, chan_sel_i, man_wr_i, man_sel_i;
    logic [13:0] man_code_i;
    logic [27:0] dac_dat_o;
    logic        dac_wrt_o, busy_o, dir_o, err_o;
    logic [13:0] code_o;
    logic [45:0] obs;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: config as plain integers, run timing by elapsed cycles.
    int          c_min, c_max, c_step, c_dwell;
    int          m_min, m_max, m_step, m_dwell, m_t, m_code;
    logic        m_busy, m_dir, m_err, m_wrt, m_chan;
    logic [27:0] m_word;

    dac_ramp_sched #(.DW(14), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_data_i(cfg_data_i), .start_i(start_i), .stop_i(stop_i),
        .chan_sel_i(chan_sel_i), .man_wr_i(man_wr_i), .man_sel_i(man_sel_i),
        .man_code_i(man_code_i), .dac_dat_o(dac_dat_o), .dac_wrt_o(dac_wrt_o),
        .busy_o(busy_o), .code_o(code_o), .dir_o(dir_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    assign obs = {dac_dat_o, dac_wrt_o, busy_o, code_o, dir_o, err_o};

    function automatic logic [45:0] expv();
        return {m_word, m_wrt, m_busy, m_code[13:0], m_dir, m_err};
    endfunction

    task automatic model_reset();
        c_min = 0; c_max = 'h3FFF; c_step = 1; c_dwell = 0;
        m_min = 0; m_max = 0; m_step = 0; m_dwell = 0; m_t = 0; m_code = 0;
        m_busy = 0; m_dir = 0; m_err = 0; m_wrt = 0; m_chan = 0; m_word = '0;
    endtask

    task automatic set_half(input logic sel, input int code);
        logic [13:0] c;
        c = code[13:0];
        if (sel) m_word[27:14] = c;
        else     m_word[13:0]  = c;
    endtask

    // Triangle sweep rule: writes fall on every (dwell+1)-th cycle after start.
    task automatic model_step(input logic st, input logic sp, input logic ch,
                              input logic mw, input logic ms, input int mc);
        int c;
        m_wrt = 0;
        if (!m_busy) begin
            if (mw) begin set_half(ms, mc); m_wrt = 1; end
            if (st && !sp) begin
                if (c_min < c_max && c_step != 0) begin
                    m_busy = 1; m_chan = ch; m_min = c_min; m_max = c_max;
                    m_step = c_step; m_dwell = c_dwell; m_t = 0;
                    m_code = c_min; m_dir = 0; m_err = 0;
                    set_half(ch, c_min); m_wrt = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            if (mw && ms != m_chan) begin set_half(ms, mc); m_wrt = 1; end
            if (sp) begin
                m_busy = 0;
            end else begin
                m_t++;
                if (m_t % (m_dwell + 1) == 0) begin
                    c = m_code;
                    if (!m_dir) begin
                        c = c + m_step;
                        if (c >= m_max) begin c = m_max; m_dir = 1; end
                    end else begin
                        c = c - m_step;
                        if (c <= m_min) begin c = m_min; m_dir = 0; end
                    end
                    m_code = c;
                    set_half(m_chan, m_code);
                    m_wrt = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic ch,
                         input logic mw, input logic ms, input int mc);
        start_i = st; stop_i = sp; chan_sel_i = ch;
        man_wr_i = mw; man_sel_i = ms; man_code_i = mc[13:0];
        model_step(st, sp, ch, mw, ms, mc);
        @(posedge clk); #1;
        start_i = 0; stop_i = 0; man_wr_i = 0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input int d);
        cfg_we_i = 1; cfg_addr_i = a; cfg_data_i = d[15:0];
        model_step(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cfg_we_i = 0;
        case (a)
            2'd0: c_min = d & 'h3FFF;
            2'd1: c_max = d & 'h3FFF;
            2'd2: c_step = d & 'h3FFF;
            default: c_dwell = d & 'hFFFF;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== 46'h0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=0", obs);
        end
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs !== expv() || dac_wrt_o !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_quiet cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
        // Mid-cycle reset pulse with a nonzero word.
        drive(0, 0, 0, 1, 1, 'h2222);
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 46'h0) begin
            n_fail++; $display("FAIL async_reset_idle got=%h exp=0", obs);
        end
        @(negedge clk); rst_n = 1;
        // Default config sweep: 0,1,2,... one write per cycle.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (obs !== expv() || code_o !== i[13:0] || dac_wrt_o !== 1'b1) begin
                n_fail++; $display("FAIL default_ramp cyc=%0d got=%h exp=%h", i, obs, expv());
            end
            drive(0, 0, 0, 0, 0, 0);
        end
        drive(0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL default_stop got=%h exp=%h", obs, expv());
        end
    endtask

    task automatic test_manual();
        drive(0, 0, 0, 1, 0, 'h0123);
        n_cmp++;
        if (obs !== expv() || dac_dat_o !== 28'h0000123 || dac_wrt_o !== 1'b1) begin
            n_fail++; $display("FAIL manual_lo got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || dac_wrt_o !== 1'b0) begin
            n_fail++; $display("FAIL manual_lo_pulse got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 1, 1, 'h1ABC);
        n_cmp++;
        if (obs !== expv() || dac_dat_o !== 28'h6AF0123 || dac_wrt_o !== 1'b1) begin
            n_fail++; $display("FAIL manual_hi got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || dac_wrt_o !== 1'b0) begin
            n_fail++; $display("FAIL manual_hi_pulse got=%h exp=%h", obs, expv());
        end
    endtask

    task automatic test_ramp();
        int exp_seq[8] = '{'h100, 'h103, 'h106, 'h108, 'h105, 'h102, 'h100, 'h103};
        int got[$];
        cfg_write(0, 'h100); cfg_write(1, 'h108); cfg_write(2, 3); cfg_write(3, 1);
        drive(0, 0, 0, 1, 1, 'h1ABC);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs !== expv() || dac_dat_o[27:14] !== 14'h1ABC || dac_wrt_o !== ((i % 2) == 0)) begin
                n_fail++; $display("FAIL ramp_cycle cyc=%0d got=%h exp=%h", i, obs, expv());
            end
            if (dac_wrt_o) got.push_back(int'(dac_dat_o[13:0]));
            drive(0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL ramp_seq idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : -1, exp_seq[i]);
            end
        end
        drive(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_stop_err();
        drive(1, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs !== expv() || busy_o !== 1'b0 || code_o !== 14'h106 || dac_wrt_o !== 1'b0) begin
                n_fail++; $display("FAIL stop_hold cyc=%0d got=%h exp=%h", i, obs, expv());
            end
            drive(0, 0, 0, 0, 0, 0);
        end
        cfg_write(0, 'h200); cfg_write(1, 'h100);
        drive(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || err_o !== 1'b1 || busy_o !== 1'b0 || dac_wrt_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_start got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || err_o !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got=%h exp=%h", obs, expv());
        end
        cfg_write(0, 'h100); cfg_write(1, 'h108);
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== expv() || busy_o !== 1'b0 || dac_wrt_o !== 1'b0) begin
                n_fail++; $display("FAIL start_stop_same cyc=%0d got=%h exp=%h", i, obs, expv());
            end
            drive(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_manual_during_ramp();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 'h0777);
        n_cmp++;
        if (obs !== expv() || dac_dat_o[27:14] !== 14'h0777 || dac_wrt_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL man_other_half got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 1, 1, 'h0555);
        n_cmp++;
        if (obs !== expv() || dac_dat_o !== {14'h0555, 14'h103} || dac_wrt_o !== 1'b1) begin
            n_fail++; $display("FAIL man_merge got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || dac_wrt_o !== 1'b0) begin
            n_fail++; $display("FAIL man_merge_single got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 1, 0, 'h0333);
        n_cmp++;
        if (obs !== expv() || dac_dat_o[13:0] !== 14'h106) begin
            n_fail++; $display("FAIL man_ramped_drop got=%h exp=%h", obs, expv());
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, (i == 2), 0, 'h0333);
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL ramp_after_drop cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
        drive(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int mn, mx, st, dw;
            mn = $urandom_range(0, 'h3F00);
            mx = mn + $urandom_range(1, 200);
            if (mx > 'h3FFF) mx = 'h3FFF;
            st = $urandom_range(1, 40);
            dw = $urandom_range(0, 3);
            if (r == 5) mx = mn;
            if (r == 6) st = 0;
            cfg_write(0, mn); cfg_write(1, mx); cfg_write(2, st); cfg_write(3, dw);
            drive(1, 0, $urandom_range(0, 1), 0, 0, 0);
            for (int i = 0; i < 40; i++) begin
                n_cmp++;
                if (obs !== expv()) begin
                    n_fail++; $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", r, i, obs, expv());
                end
                drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
                      $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 1), $urandom_range(0, 'h3FFF));
            end
            drive(0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic test_async_reset_midrun();
        cfg_write(0, 'h100); cfg_write(1, 'h180); cfg_write(2, 5); cfg_write(3, 3);
        drive(1, 0, 1, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (busy_o !== 1'b0 || dac_dat_o !== 28'h0 || code_o !== 14'h0 || obs !== 46'h0) begin
            n_fail++; $display("FAIL midrun_reset got=%h exp=0", obs);
        end
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs !== expv() || dac_wrt_o !== 1'b0) begin
                n_fail++; $display("FAIL midrun_quiet cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
        cfg_write(0, 'h100);
        drive(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== expv() || code_o !== 14'h100 || dac_dat_o !== {14'h100, 14'h0} || dac_wrt_o !== 1'b1) begin
            n_fail++; $display("FAIL restart_min got=%h exp=%h", obs, expv());
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== expv()) begin
            n_fail++; $display("FAIL restart_next got=%h exp=%h", obs, expv());
        end
    endtask

    initial begin
        cfg_we_i = 0; cfg_addr_i = 0; cfg_data_i = 0;
        start_i = 0; stop_i = 0; chan_sel_i = 0;
        man_wr_i = 0; man_sel_i = 0; man_code_i = 0;
        test_reset();
        test_manual();
        test_ramp();
        test_stop_err();
        test_manual_during_ramp();
        test_random();
        test_async_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_ramp_sched.md
# dac_ramp_sched

Sequencer for the two-channel 14-bit DAC output word. It generates a continuous triangular sweep on one selected DAC half for cavity/laser scanning and merges manual single-code writes from the PS command decoder. It owns the 28-bit DAC word and its write strobe, and sits between the command decode in `pdh_core` and the DAC output stage.

## Interface
- `DW`, default 14: DAC code width per channel.
- `DWELL_W`, default 16: dwell counter width.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we_i` in 1: one-cycle config write pulse.
- `cfg_addr_i` in 2: config register select.
  - 0 = min code
  - 1 = max code
  - 2 = step
  - 3 = dwell
- `cfg_data_i` in 16: config data. Codes and step use `[DW-1:0]`; dwell uses `[DWELL_W-1:0]`.
- `start_i` in 1: pulse that starts the sweep.
- `stop_i` in 1: pulse that stops the sweep.
- `chan_sel_i` in 1: channel to ramp, sampled with `start_i`. 0 = lower half, 1 = upper half.
- `man_wr_i` in 1: manual write request pulse.
- `man_sel_i` in 1: manual target channel (0 = lower, 1 = upper).
- `man_code_i` in DW: manual code.
- `dac_dat_o` out 2*DW: `{upper[27:14], lower[13:0]}`.
- `dac_wrt_o` out 1: one-cycle pulse on every change of `dac_dat_o`.
- `busy_o` out 1: sweep running.
- `code_o` out DW: current ramp code.
- `dir_o` out 1: sweep direction (0 = up, 1 = down).
- `err_o` out 1: last start was rejected.

## Operation
- Config registers reset to min=0x0000, max=0x3FFF, step=1, dwell=0. They are writable at any time.
- Shadow copies of the config registers and `chan_sel_i` are captured at an accepted start. Config writes made during a run take effect at the next start.
- The FSM has two states.
  - IDLE:
    - `start_i` with min<max and step≠0 goes to RUN. It sets code=min and dir=up, writes min to the selected half, and clears `err_o`.
    - An invalid start stays in IDLE, sets `err_o`, and performs no write.
  - RUN:
    - The dwell counter counts dwell+1 cycles per step, then advances the code.
    - Moving up: next = code+step, computed in DW+1 bits. If next ≥ max, the code clamps to max and dir becomes down.
    - Moving down: next = code−step, computed in DW+1 bits signed. If next ≤ min, the code clamps to min and dir becomes up.
    - Each advance writes the new code into the selected half.
    - `stop_i` goes to IDLE. The last code stays on the DAC and the dwell counter clears.
- `start_i` while in RUN is ignored.
- `start_i` and `stop_i` in the same cycle: stop wins. No run starts, or the current run stops.
- Manual writes:
  - In IDLE, a manual write is always accepted.
  - In RUN, a manual write to the non-ramped half is accepted.
  - In RUN, a manual write to the ramped half is silently dropped.
- The non-target half of `dac_dat_o` is always preserved.
- A ramp advance and an accepted manual write to the other half in the same cycle merge into one word update with one `dac_wrt_o` pulse.
- All arithmetic and comparisons are unsigned.

## Timing
- All outputs are registered.
- Reset values: `dac_dat_o`=0, `dac_wrt_o`=0, `busy_o`=0, `code_o`=0, `dir_o`=0, `err_o`=0. Reset forces IDLE immediately and asynchronously, including mid-run.
- After reset deasserts, no `dac_wrt_o` pulse occurs until a start or a manual write.
- Start sampled at edge k:
  - At edge k+1, `busy_o`=1, `dac_dat_o` carries min, and `dac_wrt_o`=1 for one cycle.
  - Subsequent writes occur at edges k+1+n·(dwell+1).
- Stop sampled at edge k: `busy_o`=0 from edge k+1, with no write at k+1 or later.
- Invalid start at edge k: `err_o`=1 from edge k+1. It stays set until the next valid start or reset.
- Manual write sampled at edge k: updated word and a `dac_wrt_o` pulse at edge k+1.
- With dwell=0, the DAC updates every cycle and `dac_wrt_o` stays high continuously during the run.

## Test plan
1. Reset:
   - Assert `rst_n`=0 mid-cycle, then release → all outputs 0 immediately.
   - No `dac_wrt_o` until stimulus is applied.
   - Config reads back as defaults, verified by a default ramp starting at 0x0000.
2. Manual write, sel 0, code 0x0123 → `dac_dat_o`=0x0000123 with one pulse. Then sel 1, 0x1ABC → 0x6AF0123 (`{0x1ABC, 0x0123}`) with one pulse.
3. Ramp:
   - Setup: min=0x0100, max=0x0108, step=3, dwell=1, chan 0, upper half preset to 0x1ABC.
   - Expected lower-half code sequence: 100, 103, 106, 108, 105, 102, 100, 103.
   - One write every 2 cycles, `dir_o` toggling at 108 and 100, upper half unchanged.
4. Stop and errors:
   - Stop after the third write → `busy_o` drops next cycle, code held at 106, no further pulses.
   - Start with min=0x0200, max=0x0100 → `err_o`=1, no write, `busy_o`=0.
   - Start and stop in the same cycle → no run.
5. Manual write during a ramp on chan 0:
   - Write 0x0777 to sel 1 → upper becomes 0x0777 and the ramp continues.
   - If the write coincides with an advance, it merges into a single pulse.
   - Write to sel 0 → dropped, ramp sequence unaffected.
6. Asynchronous reset asserted mid-run, between dwell ticks → `busy_o`, `dac_dat_o` and `code_o` go to 0 immediately. No write until a new start, which begins again from min.
